// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Two-requester round-robin sequencer for a shared ALU big mux.
//               Latches the winning requester's select/operands, holds them for
//               EXEC_CYCLES cycles, captures the ALU result and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [2:0] op0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic       req1,
  input  logic [2:0] op1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic [7:0] aluResult,
  output logic [2:0] aluSel,
  output logic [7:0] aluInA,
  output logic [7:0] aluInB,
  output logic [7:0] result,
  output logic       zero,
  output logic       done0,
  output logic       done1,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_EXEC_LOAD = 4'(EXEC_CYCLES);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       r_grant;       // requester owning the operation in flight
  logic       r_last_grant;  // requester granted most recently
  logic [2:0] r_sel;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_result;
  logic       r_zero;
  logic       w_any;
  logic       w_pick;
  logic       w_capture;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    w_any     = req0 | req1;
    w_pick    = (req0 && req1) ? ~r_last_grant : req1;
    w_capture = (r_state == S_EXEC) && (r_cnt <= 4'd1);
  end

  // Next-state logic for the IDLE -> EXEC -> DONE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_EXEC;
      S_EXEC:  if (w_capture) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant, operand latch, execution counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= 4'd0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_sel        <= 3'd0;
      r_a          <= 8'h00;
      r_b          <= 8'h00;
      r_result     <= 8'h00;
      r_zero       <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_sel        <= w_pick ? op1 : op0;
            r_a          <= w_pick ? a1 : a0;
            r_b          <= w_pick ? b1 : b0;
            r_cnt        <= C_EXEC_LOAD;
          end
        end
        S_EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
          if (w_capture) begin
            r_result <= aluResult;
            r_zero   <= (aluResult == 8'h00);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs are taken straight from registered state.
  assign aluSel = r_sel;
  assign aluInA = r_a;
  assign aluInB = r_b;
  assign result = r_result;
  assign zero   = r_zero;
  assign done0  = (r_state == S_DONE) && !r_grant;
  assign done1  = (r_state == S_DONE) &&  r_grant;
  assign busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed self-checking bench for alu_sequencer with
//               EXEC_CYCLES=1 (dut1) and EXEC_CYCLES=3 (dut3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic clk;
  int   n_tests;
  int   n_fail;

  // Bench-side ALU big mux.
  function automatic logic [7:0] alu(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0:    alu = a + b;
      3'd1:    alu = a - b;
      3'd2:    alu = a & b;
      3'd3:    alu = a | b;
      3'd4:    alu = a ^ b;
      3'd7:    alu = ~a;
      default: alu = a;
    endcase
  endfunction

  // dut1 signals
  logic       rst1, req0_1, req1_1;
  logic [2:0] op0_1, op1_1;
  logic [7:0] a0_1, b0_1, a1_1, b1_1, res_in1;
  logic [2:0] sel1;
  logic [7:0] ina1, inb1, result1;
  logic       zero1, done0_1, done1_1, busy1;

  // dut3 signals
  logic       rst3, req0_3, req1_3;
  logic [2:0] op0_3, op1_3;
  logic [7:0] a0_3, b0_3, a1_3, b1_3, res_in3;
  logic [2:0] sel3;
  logic [7:0] ina3, inb3, result3;
  logic       zero3, done0_3, done1_3, busy3;

  alu_sequencer #(.EXEC_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .req0(req0_1), .op0(op0_1), .a0(a0_1), .b0(b0_1),
    .req1(req1_1), .op1(op1_1), .a1(a1_1), .b1(b1_1),
    .aluResult(res_in1), .aluSel(sel1), .aluInA(ina1), .aluInB(inb1),
    .result(result1), .zero(zero1), .done0(done0_1), .done1(done1_1), .busy(busy1)
  );

  alu_sequencer #(.EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .req0(req0_3), .op0(op0_3), .a0(a0_3), .b0(b0_3),
    .req1(req1_3), .op1(op1_3), .a1(a1_3), .b1(b1_3),
    .aluResult(res_in3), .aluSel(sel3), .aluInA(ina3), .aluInB(inb3),
    .result(result3), .zero(zero3), .done0(done0_3), .done1(done1_3), .busy(busy3)
  );

  always_comb res_in1 = alu(sel1, ina1, inb1);
  always_comb res_in3 = alu(sel3, ina3, inb3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst1 = 1; req0_1 = 0; req1_1 = 0; op0_1 = 0; op1_1 = 0;
    a0_1 = 0; b0_1 = 0; a1_1 = 0; b1_1 = 0;
    rst3 = 1; req0_3 = 0; req1_3 = 0; op0_3 = 0; op1_3 = 0;
    a0_3 = 0; b0_3 = 0; a1_3 = 0; b1_3 = 0;
    tick();
    tick();

    // Reset values
    chk("rst_sel",   sel1, 3'd0);
    chk("rst_ina",   ina1, 8'h00);
    chk("rst_inb",   inb1, 8'h00);
    chk("rst_res",   result1, 8'h00);
    chk("rst_zero",  zero1, 1'b1);
    chk("rst_done0", done0_1, 1'b0);
    chk("rst_done1", done1_1, 1'b0);
    chk("rst_busy",  busy1, 1'b0);
    rst1 = 0;
    rst3 = 0;

    // NOT path: ~8'h0F = 8'hF0
    req0_1 = 1; op0_1 = 3'd7; a0_1 = 8'h0F; b0_1 = 8'h00;
    tick();
    chk("not_c1_sel",   sel1, 3'd7);
    chk("not_c1_ina",   ina1, 8'h0F);
    chk("not_c1_busy",  busy1, 1'b1);
    chk("not_c1_done0", done0_1, 1'b0);
    tick();
    chk("not_c2_done0", done0_1, 1'b1);
    chk("not_c2_done1", done1_1, 1'b0);
    chk("not_c2_res",   result1, 8'hF0);
    chk("not_c2_zero",  zero1, 1'b0);
    chk("not_c2_busy",  busy1, 1'b1);
    req0_1 = 0;
    tick();
    chk("not_c3_done0", done0_1, 1'b0);
    chk("not_c3_busy",  busy1, 1'b0);
    chk("not_c3_hold",  result1, 8'hF0);

    // ~8'hFF = 0 -> zero flag
    req0_1 = 1; a0_1 = 8'hFF;
    tick();
    tick();
    chk("zf_done0", done0_1, 1'b1);
    chk("zf_res",   result1, 8'h00);
    chk("zf_zero",  zero1, 1'b1);
    req0_1 = 0;
    tick();

    // Tie right after reset: requester 0 first, then requester 1
    rst1 = 1;
    tick();
    rst1 = 0;
    req0_1 = 1; op0_1 = 3'd0; a0_1 = 8'h03; b0_1 = 8'h04;
    req1_1 = 1; op1_1 = 3'd4; a1_1 = 8'hF0; b1_1 = 8'h3C;
    tick();
    chk("tie_c1_sel", sel1, 3'd0);
    chk("tie_c1_ina", ina1, 8'h03);
    tick();
    chk("tie_c2_done0", done0_1, 1'b1);
    chk("tie_c2_done1", done1_1, 1'b0);
    chk("tie_c2_res",   result1, 8'h07);
    req0_1 = 0;
    tick();
    chk("tie_c3_busy", busy1, 1'b0);
    tick();
    chk("tie_c4_sel", sel1, 3'd4);
    chk("tie_c4_ina", ina1, 8'hF0);
    chk("tie_c4_inb", inb1, 8'h3C);
    tick();
    chk("tie_c5_done1", done1_1, 1'b1);
    chk("tie_c5_done0", done0_1, 1'b0);
    chk("tie_c5_res",   result1, 8'hCC);
    req1_1 = 0;
    tick();

    // Both held continuously: done pulses alternate 0,1,0,1
    req0_1 = 1; op0_1 = 3'd1; a0_1 = 8'h10; b0_1 = 8'h01;
    req1_1 = 1; op1_1 = 3'd2; a1_1 = 8'hF0; b1_1 = 8'h0F;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("alt_exec_done0", done0_1, 1'b0);
      chk("alt_exec_done1", done1_1, 1'b0);
      tick();
      chk("alt_done0", done0_1, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("alt_done1", done1_1, (k % 2 == 1) ? 1'b1 : 1'b0);
      chk("alt_res",   result1, (k % 2 == 0) ? 8'h0F : 8'h00);
      chk("alt_zero",  zero1, (k % 2 == 1) ? 1'b1 : 1'b0);
      if (k == 3) begin
        req0_1 = 0;
        req1_1 = 0;
      end
      tick();
    end

    // EXEC_CYCLES=3, single req1: operands stable cycles 1..3, done1 at 4
    req1_3 = 1; op1_3 = 3'd3; a1_3 = 8'hA0; b1_3 = 8'h05;
    for (int c = 1; c <= 3; c++) begin
      tick();
      req1_3 = 0;
      chk("ec3_sel",   sel3, 3'd3);
      chk("ec3_ina",   ina3, 8'hA0);
      chk("ec3_inb",   inb3, 8'h05);
      chk("ec3_busy",  busy3, 1'b1);
      chk("ec3_done1", done1_3, 1'b0);
    end
    tick();
    chk("ec3_c4_done1", done1_3, 1'b1);
    chk("ec3_c4_done0", done0_3, 1'b0);
    chk("ec3_c4_busy",  busy3, 1'b1);
    chk("ec3_c4_res",   result3, 8'hA5);
    tick();
    chk("ec3_c5_busy",  busy3, 1'b0);
    chk("ec3_c5_done1", done1_3, 1'b0);

    // Reset in the middle of a requester-0 operation
    req0_3 = 1; op0_3 = 3'd7; a0_3 = 8'h55; b0_3 = 8'h11;
    tick();
    tick();
    chk("mid_busy", busy3, 1'b1);
    rst3 = 1;
    req0_3 = 0;
    tick();
    chk("mrst_busy",  busy3, 1'b0);
    chk("mrst_sel",   sel3, 3'd0);
    chk("mrst_ina",   ina3, 8'h00);
    chk("mrst_inb",   inb3, 8'h00);
    chk("mrst_res",   result3, 8'h00);
    chk("mrst_zero",  zero3, 1'b1);
    chk("mrst_done0", done0_3, 1'b0);
    chk("mrst_done1", done1_3, 1'b0);
    rst3 = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mrst_no_done0", done0_3, 1'b0);
      chk("mrst_no_busy",  busy3, 1'b0);
    end

    // First tie after reset goes to requester 0
    req0_3 = 1; op0_3 = 3'd7; a0_3 = 8'h0F;
    req1_3 = 1; op1_3 = 3'd0; a1_3 = 8'h01; b1_3 = 8'h01;
    tick();
    chk("rtie_sel", sel3, 3'd7);
    chk("rtie_ina", ina3, 8'h0F);
    tick();
    tick();
    tick();
    chk("rtie_done0", done0_3, 1'b1);
    chk("rtie_done1", done1_3, 1'b0);
    chk("rtie_res",   result3, 8'hF0);
    req0_3 = 0;
    req1_3 = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
